// File: rtl/core_pkg.sv
// Shared fetch-sequencer types and defaults.
// Imported by the fetch sequencer and its parent.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_DRAIN,
    ST_TRAP
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;

  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_sequencer.sv
// Single-issue fetch controller: one request in flight,
// decode-gated issue handshake, trap, and redirect draining.
module fetch_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        clk_en,
  input  logic        rst,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_dec_instruction,
  input  logic        i_dec_valid,
  output logic        o_issue_valid,
  input  logic        i_issue_ready,
  output logic [31:0] o_issue_pc,
  output logic [31:0] o_issue_instruction,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_trap,
  output logic [31:0] o_trap_pc,
  output logic [31:0] o_issue_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  trap_pc_q, trap_pc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC & PC_ALIGN_MASK;
      inst_q    <= '0;
      count_q   <= '0;
      trap_pc_q <= '0;
    end else if (clk_en) begin
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      count_q   <= count_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    count_d   = count_q;
    trap_pc_d = trap_pc_q;
    if (i_redirect) begin
      // Any accepted-but-unanswered request must be drained first.
      pc_d = i_redirect_pc & PC_ALIGN_MASK;
      unique case (state_q)
        ST_FETCH: state_d = i_mem_gnt    ? ST_DRAIN : ST_FETCH;
        ST_WAIT:  state_d = i_mem_rvalid ? ST_FETCH : ST_DRAIN;
        ST_DRAIN: state_d = i_mem_rvalid ? ST_FETCH : ST_DRAIN;
        default:  state_d = ST_FETCH;
      endcase
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (i_mem_gnt) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (i_mem_rvalid) begin
            inst_d  = i_mem_rdata;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!i_dec_valid) begin
            trap_pc_d = pc_q;
            state_d   = ST_TRAP;
          end else if (i_issue_ready) begin
            pc_d    = pc_q + PC_STEP;
            count_d = count_q + 32'd1;
            state_d = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (i_mem_rvalid) state_d = ST_FETCH;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    o_mem_req           = (state_q == ST_FETCH);
    o_mem_addr          = pc_q;
    o_dec_instruction   = inst_q;
    o_issue_valid       = (state_q == ST_ISSUE) && i_dec_valid
                          && !i_redirect;
    o_issue_pc          = pc_q;
    o_issue_instruction = inst_q;
    o_trap              = (state_q == ST_TRAP);
    o_trap_pc           = trap_pc_q;
    o_issue_count       = count_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer.
// Decoder model: low two bits 2'b11 means legal.
module tb_fetch_sequencer;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] dec_instruction;
  logic        dec_valid;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_pc;
  logic [31:0] issue_instruction;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] issue_count;

  int n_checks = 0;
  int n_errors = 0;

  fetch_sequencer dut (
    .clk                 (clk),
    .clk_en              (clk_en),
    .rst                 (rst),
    .o_mem_req           (mem_req),
    .o_mem_addr          (mem_addr),
    .i_mem_gnt           (mem_gnt),
    .i_mem_rvalid        (mem_rvalid),
    .i_mem_rdata         (mem_rdata),
    .o_dec_instruction   (dec_instruction),
    .i_dec_valid         (dec_valid),
    .o_issue_valid       (issue_valid),
    .i_issue_ready       (issue_ready),
    .o_issue_pc          (issue_pc),
    .o_issue_instruction (issue_instruction),
    .i_redirect          (redirect),
    .i_redirect_pc       (redirect_pc),
    .o_trap              (trap),
    .o_trap_pc           (trap_pc),
    .o_issue_count       (issue_count)
  );

  assign dec_valid = (dec_instruction[1:0] == 2'b11);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Request at exp_addr, gnt, rvalid next cycle; ends in ISSUE.
  task automatic fetch_word(input logic [31:0] exp_addr,
                            input logic [31:0] data);
    #1;
    chk("fetch_req", {31'd0, mem_req}, 32'd1);
    chk("fetch_addr", mem_addr, exp_addr);
    mem_gnt = 1'b1;
    cyc();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    #1;
    chk("wait_no_req", {31'd0, mem_req}, 32'd0);
    cyc();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  task automatic issue_ok(input logic [31:0] exp_pc,
                          input logic [31:0] exp_inst);
    issue_ready = 1'b1;
    #1;
    chk("issue_valid", {31'd0, issue_valid}, 32'd1);
    chk("issue_pc", issue_pc, exp_pc);
    chk("issue_inst", issue_instruction, exp_inst);
    cyc();
    issue_ready = 1'b0;
  endtask

  initial begin
    clk_en      = 1'b1;
    rst         = 1'b1;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    issue_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    cyc();
    cyc();
    chk("rst_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_trap_pc", trap_pc, 32'd0);
    chk("rst_count", issue_count, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_dec", dec_instruction, 32'd0);
    rst = 1'b0;
    cyc();

    // Straight-line issue at 0, 4, 8 with 2-cycle latency.
    for (int i = 0; i < 3; i++) begin
      fetch_word(32'(i * 4), 32'h0000_0013);
      issue_ok(32'(i * 4), 32'h0000_0013);
    end
    chk("count3", issue_count, 32'd3);

    // Backpressure at pc 0xC.
    fetch_word(32'h0000_000C, 32'h0000_0113);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", {31'd0, issue_valid}, 32'd1);
      chk("bp_pc", issue_pc, 32'h0000_000C);
      chk("bp_inst", issue_instruction, 32'h0000_0113);
      chk("bp_no_req", {31'd0, mem_req}, 32'd0);
      cyc();
    end
    issue_ok(32'h0000_000C, 32'h0000_0113);
    chk("count4", issue_count, 32'd4);

    // Illegal word at 0x10 traps.
    fetch_word(32'h0000_0010, 32'h0000_0000);
    #1;
    chk("ill_no_issue", {31'd0, issue_valid}, 32'd0);
    cyc();
    chk("trap_set", {31'd0, trap}, 32'd1);
    chk("trap_pc", trap_pc, 32'h0000_0010);
    chk("trap_no_req", {31'd0, mem_req}, 32'd0);
    cyc();
    chk("trap_hold", {31'd0, trap}, 32'd1);
    chk("trap_no_req2", {31'd0, mem_req}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    cyc();
    redirect = 1'b0;
    chk("trap_clr", {31'd0, trap}, 32'd0);
    chk("trap_pc_keep", trap_pc, 32'h0000_0010);
    chk("redir_req", {31'd0, mem_req}, 32'd1);
    chk("redir_addr", mem_addr, 32'h0000_0100);

    // Redirect during WAIT; stale response 3 cycles later.
    mem_gnt = 1'b1;
    cyc();
    mem_gnt     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    cyc();
    redirect = 1'b0;
    chk("drain_no_req", {31'd0, mem_req}, 32'd0);
    cyc();
    cyc();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("drain_no_issue", {31'd0, issue_valid}, 32'd0);
    cyc();
    mem_rvalid = 1'b0;
    chk("after_drain_valid", {31'd0, issue_valid}, 32'd0);
    fetch_word(32'h0000_0200, 32'h0020_0093);
    issue_ok(32'h0000_0200, 32'h0020_0093);
    chk("count5", issue_count, 32'd5);

    // Redirect coincident with gnt, then re-redirect in DRAIN.
    #1;
    chk("pre_addr", mem_addr, 32'h0000_0204);
    mem_gnt     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0280;
    cyc();
    mem_gnt     = 1'b0;
    redirect_pc = 32'h0000_0300;
    chk("drain2_no_req", {31'd0, mem_req}, 32'd0);
    cyc();
    redirect   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_0013;
    cyc();
    mem_rvalid = 1'b0;
    chk("drain2_no_issue", {31'd0, issue_valid}, 32'd0);
    fetch_word(32'h0000_0300, 32'h0000_0013);
    issue_ok(32'h0000_0300, 32'h0000_0013);
    chk("count6", issue_count, 32'd6);

    // Grant while disabled is ignored.
    clk_en  = 1'b0;
    mem_gnt = 1'b1;
    cyc();
    clk_en = 1'b1;
    chk("ce_gnt_ignored", {31'd0, mem_req}, 32'd1);
    cyc();
    mem_gnt = 1'b0;
    chk("ce_wait", {31'd0, mem_req}, 32'd0);

    // Response arrives while disabled and is held.
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0030_0093;
      end
      cyc();
      chk("ce_dec_hold", dec_instruction, 32'h0000_0013);
      chk("ce_no_issue", {31'd0, issue_valid}, 32'd0);
      chk("ce_no_req", {31'd0, mem_req}, 32'd0);
    end
    clk_en = 1'b1;
    cyc();
    mem_rvalid = 1'b0;
    chk("ce_capture", dec_instruction, 32'h0030_0093);
    chk("ce_issue_valid", {31'd0, issue_valid}, 32'd1);
    chk("ce_issue_pc", issue_pc, 32'h0000_0304);

    // Reset during ISSUE, even with clk_en low.
    rst    = 1'b1;
    clk_en = 1'b0;
    cyc();
    rst    = 1'b0;
    clk_en = 1'b1;
    chk("rst2_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst2_count", issue_count, 32'd0);
    chk("rst2_addr", mem_addr, 32'd0);
    chk("rst2_req", {31'd0, mem_req}, 32'd1);
    chk("rst2_dec", dec_instruction, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Single-issue fetch/decode controller. Sequences the decoder.
- Owns the PC and issues one instruction-memory request at a time.
- Captures the returned word and drives it into the decoder.
- Uses the decoder's valid flag to either issue the instruction downstream with a valid/ready handshake or trap on an illegal encoding.
- Handles redirects (branch/jump/exception) mid-flight by discarding stale memory responses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
PC_STEP, 4, PC increment after each issued instruction

Ports:
clk  in  1  clock
clk_en  in  1  clock enable; state advances only when 1 (reset excepted)
rst  in  1  synchronous active-high reset
o_mem_req  out  1  instruction fetch request
o_mem_addr  out  32  fetch address (= PC)
i_mem_gnt  in  1  request accepted this cycle
i_mem_rvalid  in  1  response valid (exactly one per granted request, >=1 cycle after grant)
i_mem_rdata  in  32  response word
o_dec_instruction  out  32  word presented to decoder
i_dec_valid  in  1  decoder valid flag for o_dec_instruction
o_issue_valid  out  1  instruction available downstream
i_issue_ready  in  1  downstream accepts
o_issue_pc  out  32  PC of issued instruction
o_issue_instruction  out  32  issued instruction word
i_redirect  in  1  redirect request (single-cycle pulse, may repeat)
i_redirect_pc  in  32  redirect target
o_trap  out  1  illegal instruction trap held
o_trap_pc  out  32  PC of the illegal instruction
o_issue_count  out  32  number of completed issue handshakes, wraps at 2^32

Behaviour:
- Reset: synchronous, active-high. rst=1 at a rising edge takes effect regardless of clk_en.
  - State FETCH, pc=RESET_PC, inst_reg=0, count=0.
  - o_trap=0, o_trap_pc=0, o_issue_valid=0.
  - o_mem_req is asserted in the first cycle after rst deasserts.
- clk_en=0: every register holds. Combinational outputs follow the held state.
  - o_mem_req stays asserted; a gnt seen while clk_en=0 is ignored, so memory must not take it as accepted.
- States: FETCH, WAIT, ISSUE, DRAIN, TRAP.
  - FETCH: o_mem_req=1, o_mem_addr=pc. On i_mem_gnt -> WAIT.
  - WAIT: on i_mem_rvalid, inst_reg<=i_mem_rdata and go to ISSUE. Minimum request-to-issue latency is 2 cycles (gnt at cycle n, rvalid at n+1, ISSUE at n+2).
  - ISSUE: o_dec_instruction=inst_reg, which is always driven from inst_reg.
    - i_dec_valid=1: o_issue_valid=1, o_issue_pc=pc, o_issue_instruction=inst_reg. On valid&ready: pc<=pc+PC_STEP (mod 2^32), count++, -> FETCH. There is no prefetch, so at most one instruction is in flight.
    - i_dec_valid=0: -> TRAP, o_trap_pc<=pc. No issue.
  - TRAP: o_trap=1, no requests, no issue. Exited only by redirect or reset.
  - DRAIN: wait for the single outstanding response. On rvalid, discard it and go to FETCH at the redirected pc.
- Redirect (any state, clk_en=1). Always pc<=i_redirect_pc with bits [1:0] forced to 0. Next state:
  - FETCH without gnt -> FETCH, issuing the new address next cycle.
  - FETCH with gnt in the same cycle -> DRAIN, since the old request was accepted.
  - WAIT without rvalid -> DRAIN.
  - WAIT with rvalid in the same cycle -> response discarded -> FETCH.
  - DRAIN without rvalid -> stays DRAIN with pc updated. This is the newest redirect wins rule.
  - DRAIN with rvalid -> FETCH.
  - ISSUE -> FETCH. o_issue_valid is forced 0 while i_redirect=1, so no handshake and no count increment that cycle.
  - TRAP -> FETCH, o_trap cleared. o_trap_pc holds its value until the next trap.
- o_issue_valid is never dropped without either a handshake or a redirect. pc and instruction are stable while valid&!ready.
- The count wraps 32'hFFFF_FFFF -> 0.

Decomposition:
- Shared package (core_pkg): fetch_state_e enum; RESET_PC default; PC_STEP default.
- No sub-module.
- The decoder is instantiated by the parent and connected via o_dec_instruction/i_dec_valid. The parent's decoder instance shares clk, clk_en, rst.

Test Plan:
- Reset, memory returns 32'h00000013 (addi) one cycle after gnt, ready=1 -> issues at pc 0,4,8. Request-to-issue latency is 2 cycles. count=3 after three issues.
- Backpressure: ready=0 for 5 cycles while ISSUE -> o_issue_valid held. pc/instruction stable. No new o_mem_req. Issue completes on ready=1, count +1.
- Illegal word 32'h00000000 at pc 0x10 -> o_trap=1, o_trap_pc=0x10, no requests. Redirect to 0x103 -> o_trap=0, next o_mem_addr=0x100.
- Redirect to 0x200 while WAIT with rvalid 3 cycles later -> the stale response is not issued. The next request is at 0x200 and the first issued pc is 0x200.
- Redirect coincident with gnt in FETCH, then a second redirect to 0x300 during DRAIN -> one response discarded. The next request is at 0x300.
- clk_en=0 for 4 cycles mid-WAIT with rvalid pulsed during that window held by memory until clk_en=1 -> no state change while disabled. The capture occurs on the first enabled cycle. rst=1 during ISSUE -> FETCH at RESET_PC, count=0, o_issue_valid=0.
